// File: rtl/mux_share_ctrl.sv
// Round-robin sequencer sharing one mux-fed datapath unit between two requesters.
// Optional WAIT timeout with err flag: define MUX_SHARE_TIMEOUT_EN.
module mux_share_ctrl #(
    parameter int P   = 32,
    parameter int TMO = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_0,
    input  logic         req_1,
    input  logic [P-1:0] D_0,
    input  logic [P-1:0] D_1,
    input  logic         done,
    output logic         MS,
    output logic [P-1:0] D_out,
    output logic         start,
    output logic         ack_0,
    output logic         ack_1,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    if (TMO < 2) begin : g_tmo_check
        $error("mux_share_ctrl: TMO must be at least 2");
    end

    state_t state;
    logic   last;
    logic   winner;

    // A lone request wins outright; on a tie the requester not served last wins.
    assign winner = req_1 & (~req_0 | ~last);

`ifdef MUX_SHARE_TIMEOUT_EN
    localparam int CW = $clog2(TMO);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
    assign err = 1'b0;
`endif

    // NOTE: all state and outputs use non-blocking assignments so every register
    // samples the pre-edge values and no output depends combinationally on inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            MS      <= 1'b0;
            D_out   <= '0;
            last    <= 1'b1;
            start   <= 1'b0;
            ack_0   <= 1'b0;
            ack_1   <= 1'b0;
            busy    <= 1'b0;
`ifdef MUX_SHARE_TIMEOUT_EN
            err     <= 1'b0;
            tmo_cnt <= '0;
`endif
        end else begin
            start <= 1'b0;
            ack_0 <= 1'b0;
            ack_1 <= 1'b0;
`ifdef MUX_SHARE_TIMEOUT_EN
            err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_0 | req_1) begin
                        state <= START;
                        MS    <= winner;
                        D_out <= winner ? D_1 : D_0;
                        start <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT;
`ifdef MUX_SHARE_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    // done wins over a coinciding timeout, so err stays low then.
                    if (done) begin
                        state <= RESP;
                        ack_0 <= ~MS;
                        ack_1 <= MS;
                    end
`ifdef MUX_SHARE_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state <= RESP;
                        ack_0 <= ~MS;
                        ack_1 <= MS;
                        err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                    last  <= MS;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
